// File: rtl/udpip_transmitter.sv
// udpip_transmitter: buffers a UDP payload, computes the UDP (with pseudo-header)
// and IPv4 header checksums, then streams the 28-byte header plus payload.
module udpip_transmitter #(
  parameter logic [31:0] SRC_IP      = 32'hC0A80001,
  parameter logic [31:0] DST_IP      = 32'hC0A80002,
  parameter logic [15:0] SRC_PORT    = 16'h1234,
  parameter logic [15:0] DST_PORT    = 16'h5678,
  parameter logic [7:0]  TTL         = 8'd64,
  parameter int          MAX_PAYLOAD = 228
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_in,
  input  logic       tx_in_valid,
  input  logic       tx_in_first,
  input  logic       tx_in_last,
  output logic       tx_in_ready,
  output logic [7:0] wrdata,
  output logic       wr_valid,
  output logic       wr_first,
  output logic       wr_last,
  input  logic       wr_ready,
  output logic       tx_drop,
  output logic [2:0] state
);

  // Payload is split into even/odd byte banks so a full 16-bit word reads per cycle.
  localparam int         WORDS   = (MAX_PAYLOAD + 1) / 2;
  localparam int         AW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [8:0] WORDS9  = 9'(WORDS);
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, UDP_SUM = 3'd2, IP_SUM = 3'd3, SEND = 3'd4, DROP = 3'd5
  } state_t;

  state_t      state_reg;
  logic [7:0]  len_reg;
  logic [15:0] id_reg;
  logic [8:0]  idx_reg;
  logic [7:0]  cnt_reg;
  logic        fold_reg;
  logic [31:0] acc_reg;
  logic [15:0] udp_csum_reg;
  logic [15:0] ip_csum_reg;

  logic [7:0] even_mem [0:WORDS-1];
  logic [7:0] odd_mem  [0:WORDS-1];
  logic [7:0] rd_even_reg;
  logic [7:0] rd_odd_reg;

  logic [15:0] sum_word, hdr_w, csum_c;
  logic [31:0] folded;
  logic [7:0]  pay_w, n_words, last_cnt, mem_pos, send_byte;
  logic [8:0]  odd_pos, total9, nxt_idx, rd_pos9;
  logic [AW-1:0] rd_word, wr_word;
  logic        mem_we, send_xfer, send_load;

  // Header word w (0..13) of the datagram, big-endian
  function automatic logic [15:0] hdr_word(input logic [3:0] w, input logic [7:0] len,
                                           input logic [15:0] id, input logic [15:0] ipc,
                                           input logic [15:0] udpc);
    case (w)
      4'd0:    return 16'h4500;
      4'd1:    return 16'd28 + {8'h00, len};
      4'd2:    return id;
      4'd3:    return 16'h0000;
      4'd4:    return {TTL, 8'h11};
      4'd5:    return ipc;
      4'd6:    return SRC_IP[31:16];
      4'd7:    return SRC_IP[15:0];
      4'd8:    return DST_IP[31:16];
      4'd9:    return DST_IP[15:0];
      4'd10:   return SRC_PORT;
      4'd11:   return DST_PORT;
      4'd12:   return 16'd8 + {8'h00, len};
      4'd13:   return udpc;
      default: return 16'h0000;
    endcase
  endfunction

  assign tx_in_ready = (state_reg == IDLE) || (state_reg == LOAD) || (state_reg == DROP);
  assign state       = state_reg;
  assign n_words     = 8'(({1'b0, len_reg} + 9'd1) >> 1);
  assign last_cnt    = 8'd9 + n_words;
  assign total9      = 9'd28 + {1'b0, len_reg};
  assign folded      = {16'h0000, acc_reg[15:0]} + {16'h0000, acc_reg[31:16]};
  assign csum_c      = ~acc_reg[15:0];
  assign send_xfer   = wr_valid && wr_ready;
  assign send_load   = (state_reg == SEND) && (!wr_valid || wr_ready) &&
                       !(send_xfer && wr_last) && (idx_reg < total9);
  assign nxt_idx     = send_load ? idx_reg + 9'd1 : idx_reg;

  // Word fed to the checksum accumulator this cycle
  always_comb begin
    sum_word = 16'h0000;
    pay_w    = cnt_reg - 8'd10;
    odd_pos  = {pay_w, 1'b1};
    if (state_reg == UDP_SUM) begin
      case (cnt_reg)
        8'd0:    sum_word = SRC_IP[31:16];
        8'd1:    sum_word = SRC_IP[15:0];
        8'd2:    sum_word = DST_IP[31:16];
        8'd3:    sum_word = DST_IP[15:0];
        8'd4:    sum_word = 16'h0011;
        8'd5:    sum_word = 16'd8 + {8'h00, len_reg};
        8'd6:    sum_word = SRC_PORT;
        8'd7:    sum_word = DST_PORT;
        8'd8:    sum_word = 16'd8 + {8'h00, len_reg};
        8'd9:    sum_word = 16'h0000;
        default: sum_word = {rd_even_reg, (odd_pos >= {1'b0, len_reg}) ? 8'h00 : rd_odd_reg};
      endcase
    end else if (state_reg == IP_SUM) begin
      sum_word = hdr_word(cnt_reg[3:0], len_reg, id_reg, 16'h0000, 16'h0000);
    end
  end

  // Buffer read address runs one step ahead so registered data lines up with use
  always_comb begin
    rd_pos9 = 9'd0;
    if (state_reg == UDP_SUM) begin
      rd_pos9 = (cnt_reg >= 8'd9) ? {1'b0, cnt_reg - 8'd9} : 9'd0;
    end else if (state_reg == SEND) begin
      rd_pos9 = (nxt_idx >= 9'd28) ? ((nxt_idx - 9'd28) >> 1) : 9'd0;
    end
    rd_word = (rd_pos9 < WORDS9) ? AW'(rd_pos9) : '0;
  end

  // Next outgoing byte: header field or buffered payload
  always_comb begin
    hdr_w = hdr_word(idx_reg[4:1], len_reg, id_reg, ip_csum_reg, udp_csum_reg);
    if (idx_reg < 9'd28) send_byte = idx_reg[0] ? hdr_w[7:0] : hdr_w[15:8];
    else                 send_byte = idx_reg[0] ? rd_odd_reg : rd_even_reg;
  end

  // Payload write position; the overflowing byte is never stored
  always_comb begin
    mem_we  = 1'b0;
    mem_pos = len_reg;
    if (tx_in_valid) begin
      if (state_reg == IDLE && tx_in_first) begin
        mem_we  = 1'b1;
        mem_pos = 8'd0;
      end else if (state_reg == LOAD) begin
        if (tx_in_first) begin
          mem_we  = 1'b1;
          mem_pos = 8'd0;
        end else if (len_reg != MAX_LEN) begin
          mem_we = 1'b1;
        end
      end
    end
    wr_word = AW'(mem_pos >> 1);
  end

  // Payload buffer banks with registered read
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (mem_pos[0]) odd_mem[wr_word]  <= tx_in;
      else            even_mem[wr_word] <= tx_in;
    end
    rd_even_reg <= even_mem[rd_word];
    rd_odd_reg  <= odd_mem[rd_word];
  end

  // Main FSM: load, checksum passes, and byte streaming with backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      len_reg      <= 8'd0;
      id_reg       <= 16'h0000;
      idx_reg      <= 9'd0;
      cnt_reg      <= 8'd0;
      fold_reg     <= 1'b0;
      acc_reg      <= 32'h0;
      udp_csum_reg <= 16'h0000;
      ip_csum_reg  <= 16'h0000;
      wrdata       <= 8'h00;
      wr_valid     <= 1'b0;
      wr_first     <= 1'b0;
      wr_last      <= 1'b0;
      tx_drop      <= 1'b0;
    end else begin
      tx_drop <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg  <= 8'd0;
          acc_reg  <= 32'h0;
          fold_reg <= 1'b0;
          if (tx_in_valid && tx_in_first) begin
            len_reg   <= 8'd1;
            state_reg <= tx_in_last ? UDP_SUM : LOAD;
          end
        end
        LOAD: begin
          cnt_reg  <= 8'd0;
          acc_reg  <= 32'h0;
          fold_reg <= 1'b0;
          if (tx_in_valid) begin
            if (tx_in_first) begin
              len_reg <= 8'd1;
              if (tx_in_last) state_reg <= UDP_SUM;
            end else if (len_reg == MAX_LEN) begin
              tx_drop   <= 1'b1;
              state_reg <= tx_in_last ? IDLE : DROP;
            end else begin
              len_reg <= len_reg + 8'd1;
              if (tx_in_last) state_reg <= UDP_SUM;
            end
          end
        end
        DROP: begin
          if (tx_in_valid && tx_in_last) state_reg <= IDLE;
        end
        UDP_SUM: begin
          if (!fold_reg) begin
            acc_reg <= acc_reg + {16'h0000, sum_word};
            cnt_reg <= cnt_reg + 8'd1;
            if (cnt_reg == last_cnt) fold_reg <= 1'b1;
          end else if (acc_reg[31:16] != 16'h0000) begin
            acc_reg <= folded;
          end else begin
            udp_csum_reg <= (csum_c == 16'h0000) ? 16'hFFFF : csum_c;
            state_reg    <= IP_SUM;
            cnt_reg      <= 8'd0;
            acc_reg      <= 32'h0;
            fold_reg     <= 1'b0;
          end
        end
        IP_SUM: begin
          if (!fold_reg) begin
            acc_reg <= acc_reg + {16'h0000, sum_word};
            cnt_reg <= cnt_reg + 8'd1;
            if (cnt_reg == 8'd9) fold_reg <= 1'b1;
          end else if (acc_reg[31:16] != 16'h0000) begin
            acc_reg <= folded;
          end else begin
            ip_csum_reg <= csum_c;
            state_reg   <= SEND;
            idx_reg     <= 9'd0;
            fold_reg    <= 1'b0;
          end
        end
        SEND: begin
          if (send_xfer && wr_last) begin
            wr_valid  <= 1'b0;
            wr_last   <= 1'b0;
            id_reg    <= id_reg + 16'h0001;
            state_reg <= IDLE;
          end else if (send_load) begin
            wrdata   <= send_byte;
            wr_valid <= 1'b1;
            wr_first <= (idx_reg == 9'd0);
            wr_last  <= (idx_reg == total9 - 9'd1);
            idx_reg  <= idx_reg + 9'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udpip_transmitter.sv
// tb_udpip_transmitter: scoreboard bench for the UDP/IPv4 transmitter.
module tb_udpip_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_in = 8'h00;
  logic       tx_in_valid = 1'b0;
  logic       tx_in_first = 1'b0;
  logic       tx_in_last = 1'b0;
  logic       tx_in_ready;
  logic [7:0] wrdata;
  logic       wr_valid, wr_first, wr_last;
  logic       wr_ready;
  logic       tx_drop;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       f;
    logic       l;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] lit [0:31];
  logic       mon_en = 1'b1;
  logic       rand_ready = 1'b0;
  logic       ready_force = 1'b1;
  int         drop_cnt = 0;
  int         xfer_cnt = 0;

  udpip_transmitter dut (
    .clk(clk), .rst(rst), .tx_in(tx_in), .tx_in_valid(tx_in_valid),
    .tx_in_first(tx_in_first), .tx_in_last(tx_in_last), .tx_in_ready(tx_in_ready),
    .wrdata(wrdata), .wr_valid(wr_valid), .wr_first(wr_first), .wr_last(wr_last),
    .wr_ready(wr_ready), .tx_drop(tx_drop), .state(state)
  );

  always #5 clk = ~clk;

  // Link-side ready: forced level or random toggling
  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stall stability
  initial begin
    logic       hv;
    logic [7:0] hd;
    logic       hf, hl;
    exp_t       e;
    hv = 1'b0;
    hd = 8'h00;
    hf = 1'b0;
    hl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hv = 1'b0;
      end else begin
        if (tx_drop) drop_cnt++;
        if (mon_en && hv) begin
          checks++;
          if (!wr_valid || wrdata !== hd || wr_first !== hf || wr_last !== hl) begin
            errors++;
            $display("FAIL stall_hold got v%b %h f%b l%b expected v1 %h f%b l%b",
                     wr_valid, wrdata, wr_first, wr_last, hd, hf, hl);
          end
        end
        if (mon_en && wr_valid && wr_ready) begin
          xfer_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte got %h expected no transfer", wrdata);
          end else begin
            e = exp_q.pop_front();
            if (wrdata !== e.d || wr_first !== e.f || wr_last !== e.l) begin
              errors++;
              $display("FAIL byte got %h f%b l%b expected %h f%b l%b",
                       wrdata, wr_first, wr_last, e.d, e.f, e.l);
            end
          end
        end
        hv = wr_valid && !wr_ready;
        hd = wrdata;
        hf = wr_first;
        hl = wr_last;
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_bytes(input logic [7:0] d[$]);
    exp_t e;
    for (int i = 0; i < d.size(); i++) begin
      e.d = d[i];
      e.f = (i == 0);
      e.l = (i == d.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  // Reference datagram built byte by byte from pay_q
  task automatic push_model(input logic [15:0] id);
    logic [7:0]  d[$];
    logic [31:0] s;
    logic [15:0] c, tl, ul;
    int          n;
    n  = pay_q.size();
    tl = 16'(28 + n);
    ul = 16'(8 + n);
    d  = {8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0], 8'h00, 8'h00,
          8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01,
          8'hC0, 8'hA8, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
          ul[15:8], ul[7:0], 8'h00, 8'h00};
    s = 32'h0;
    for (int i = 0; i < 20; i += 2) s += {16'h0, d[i], d[i+1]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    c = ~s[15:0];
    d[10] = c[15:8];
    d[11] = c[7:0];
    s = 32'hC0A8 + 32'h0001 + 32'hC0A8 + 32'h0002 + 32'h0011 + {16'h0, ul};
    for (int i = 20; i < 28; i += 2) s += {16'h0, d[i], d[i+1]};
    for (int i = 0; i < n; i += 2) s += {16'h0, pay_q[i], (i + 1 < n) ? pay_q[i+1] : 8'h00};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    c = ~s[15:0];
    if (c == 16'h0000) c = 16'hFFFF;
    d[26] = c[15:8];
    d[27] = c[7:0];
    for (int i = 0; i < n; i++) d.push_back(pay_q[i]);
    push_bytes(d);
  endtask

  task automatic drive_payload();
    for (int i = 0; i < pay_q.size(); i++) begin
      @(posedge clk);
      #1;
      tx_in       = pay_q[i];
      tx_in_valid = 1'b1;
      tx_in_first = (i == 0);
      tx_in_last  = (i == pay_q.size() - 1);
    end
    @(posedge clk);
    #1;
    tx_in_valid = 1'b0;
    tx_in_first = 1'b0;
    tx_in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wr_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk({name, "_idle"}, {29'd0, state}, 32'd0);
    $display("pkt %s payload %0d bytes done after %0d cycles", name, pay_q.size(), n);
  endtask

  initial begin
    logic [7:0] q[$];
    int n, cnt, x0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_state",    {29'd0, state}, 32'd0);
    chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_wr_first", {31'd0, wr_first}, 32'd0);
    chk("rst_wr_last",  {31'd0, wr_last}, 32'd0);
    chk("rst_tx_drop",  {31'd0, tx_drop}, 32'd0);
    chk("rst_wrdata",   {24'd0, wrdata}, 32'd0);
    chk("rst_ready",    {31'd0, tx_in_ready}, 32'd1);

    // DE AD BE EF, hand-computed datagram
    lit = '{8'h45, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h40, 8'h11, 8'hF9, 8'h79, 8'hC0, 8'hA8, 8'h00, 8'h01,
            8'hC0, 8'hA8, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
            8'h00, 8'h0C, 8'h78, 8'h38, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(lit[i]);
    push_bytes(q);
    pay_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    drive_payload();
    wait_drain("deadbeef_id0", 400);

    // Same payload again: ID 1, header checksum F978
    q[5]  = 8'h01;
    q[10] = 8'hF9;
    q[11] = 8'h78;
    push_bytes(q);
    drive_payload();
    wait_drain("deadbeef_id1", 400);

    // Single byte, first and last together, odd padding
    pay_q = {8'hAB};
    push_model(16'h0002);
    drive_payload();
    wait_drain("one_byte", 400);

    // 100-byte payload with random backpressure
    pay_q.delete();
    for (int i = 0; i < 100; i++) pay_q.push_back(8'((i * 37 + 5) & 255));
    push_model(16'h0003);
    rand_ready = 1'b1;
    drive_payload();
    wait_drain("hundred_stall", 3000);
    rand_ready = 1'b0;

    // Oversize payload is dropped with a single pulse and nothing sent
    drop_cnt = 0;
    x0 = xfer_cnt;
    pay_q.delete();
    for (int i = 0; i < 229; i++) pay_q.push_back(8'(i));
    drive_payload();
    repeat (20) @(posedge clk);
    #1;
    chk("drop_pulses", 32'(drop_cnt), 32'd1);
    chk("drop_no_bytes", 32'(xfer_cnt - x0), 32'd0);
    chk("drop_state", {29'd0, state}, 32'd0);
    pay_q = {8'h01, 8'h02, 8'h03, 8'h04};
    push_model(16'h0004);
    drive_payload();
    wait_drain("after_drop", 400);

    // Reset while streaming byte 10
    mon_en = 1'b0;
    pay_q = {8'h11, 8'h22, 8'h33, 8'h44};
    drive_payload();
    n = 0;
    cnt = 0;
    while (cnt < 10 && n < 300) begin
      @(negedge clk);
      if (wr_valid && wr_ready) cnt++;
      n++;
    end
    chk("rst_mid_reached", 32'(cnt), 32'd10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_mid_state", {29'd0, state}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    pay_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    push_model(16'h0000);
    drive_payload();
    wait_drain("after_reset", 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udpip_transmitter.md
# udpip_transmitter

Builds an IPv4/UDP datagram around a user payload and streams it to the link-side byte interface. It is the transmit counterpart of the byte-stream UDP/IP receive path. Payload bytes arrive on a first/last/valid stream and are buffered. The block then computes the UDP checksum (including the pseudo-header) and the IPv4 header checksum, and emits the 28-byte header followed by the payload with output backpressure.

## Interface
Parameters:
- SRC_IP, 32'hC0A80001, IPv4 source address
- DST_IP, 32'hC0A80002, IPv4 destination address
- SRC_PORT, 16'h1234, UDP source port
- DST_PORT, 16'h5678, UDP destination port
- TTL, 8'd64, IPv4 time-to-live
- MAX_PAYLOAD, 228, maximum payload bytes (total datagram ≤ 256)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tx_in  in  8  payload byte
- tx_in_valid  in  1  payload byte valid
- tx_in_first  in  1  first payload byte
- tx_in_last  in  1  last payload byte
- tx_in_ready  out  1  block accepts payload (IDLE/LOAD/DROP)
- wrdata  out  8  datagram byte to link
- wr_valid  out  1  wrdata valid
- wr_first  out  1  first datagram byte (0x45)
- wr_last  out  1  last datagram byte
- wr_ready  in  1  link accepts byte this cycle
- tx_drop  out  1  one-cycle pulse: payload discarded (oversize)
- state  out  3  FSM state, for debug

## Operation
- State encoding: IDLE=0, LOAD=1, UDP_SUM=2, IP_SUM=3, SEND=4, DROP=5.
- IDLE: a valid byte with tx_in_first stores the byte at buffer[0], sets len=1, then goes to LOAD. If tx_in_last is also set, len=1 and the FSM goes directly to UDP_SUM. Valid bytes without first are ignored.
- LOAD: each valid byte goes to buffer[len] and len increments. On tx_in_last, go to UDP_SUM. A new tx_in_first restarts at buffer[0] with len=1.
- Overflow: a byte arriving when len==MAX_PAYLOAD is discarded. The FSM goes to DROP, pulses tx_drop, and swallows input through tx_in_last, then returns to IDLE.
- Header fields, big-endian:
  - 0x45, TOS 0x00, total length 28+len, ID = packet counter
  - flags/fragment 0x0000, TTL, protocol 0x11, header checksum, SRC_IP, DST_IP
  - SRC_PORT, DST_PORT, UDP length 8+len, UDP checksum
- Packet counter: 16 bits, reset 0, increments after each sent datagram, wraps 0xFFFF→0x0000.
- UDP_SUM: 32-bit accumulator, one 16-bit word per cycle, summing:
  - pseudo-header words: SRC_IP, DST_IP, 0x0011, UDP length
  - UDP header with checksum field 0
  - payload pairs; an odd final byte is padded as {byte,8'h00}
  - Then fold (acc = acc[15:0]+acc[31:16]) until acc[31:16]==0, and complement.
  - A complemented result of 0x0000 is transmitted as 0xFFFF.
- IP_SUM: same word-per-cycle sum over the ten header words with the checksum field 0, folded and complemented. No 0xFFFF substitution.
- SEND: bytes 0..27 are header, bytes 28..27+len are payload. On the last byte accepted, increment the ID and return to IDLE.

## Timing
- Reset values: state=IDLE, wr_valid/wr_first/wr_last/tx_drop=0, wrdata=0, packet ID=0, len=0. tx_in_ready=1 after reset.
- tx_in_ready is 0 in UDP_SUM, IP_SUM and SEND. Input is ignored whenever tx_in_ready=0.
- UDP_SUM latency: 10 + ceil(len/2) cycles of summing, plus up to 2 fold cycles.
- IP_SUM latency: 10 cycles plus up to 2 fold cycles.
- wrdata/wr_valid/wr_first/wr_last are registered. A byte transfers on a cycle where wr_valid && wr_ready.
- While wr_ready=0, all outputs hold stable. With wr_ready held high, one byte is sent per cycle and no gaps are allowed.
- The first wr_valid occurs no later than 2 cycles after IP_SUM completes.
- wr_first is asserted on byte 0 only; wr_last on byte 27+len only. They are never both set, since the minimum datagram is 29 bytes.
- rst mid-packet, in any state, returns to IDLE next cycle: wr_valid drops immediately, the buffer is discarded, and the packet ID resets to 0.
- tx_drop is exactly one cycle wide, asserted the cycle after the overflowing byte.

## Test plan
- Payload DE AD BE EF (first on DE, last on EF), wr_ready=1:
  - expect 32 bytes: 45 00 00 20 00 00 00 00 40 11 F9 79 C0 A8 00 01 C0 A8 00 02 12 34 56 78 00 0C 78 38 DE AD BE EF
  - wr_first on byte 0, wr_last on byte 31.
- Same payload sent twice: second datagram has ID 0x0001 and header checksum 0xF978.
- 1-byte payload 0xAB (first and last together): total length 0x001D, UDP length 0x0009, odd-pad checksum correct. The receiver path accepts it and outputs 0xAB.
- Random wr_ready toggling on a 100-byte payload: byte sequence identical to the wr_ready=1 run, outputs stable during stalls.
- 229-byte payload: tx_drop pulses once, nothing is sent, and the next 4-byte payload is sent correctly with ID unchanged.
- rst asserted during SEND at byte 10: wr_valid=0 the next cycle. The following packet starts at 0x45 with ID 0x0000.
